// File: rtl/skinny_msk_pkg.sv
// Shared SKINNY definitions: the 6-bit round-constant LFSR steps, the
// c0/c1 field layout of a constant, and the sequencer state encoding.
package skinny_msk_pkg;

    localparam int RC_W = 6;

    // rc[3:0] feeds c0, rc[5:4] feeds c1
    localparam int C0_LSB = 0;
    localparam int C0_W   = 4;
    localparam int C1_LSB = 4;
    localparam int C1_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WIND = 2'd1,
        RUN  = 2'd2
    } rc_state_e;

    function automatic logic [RC_W-1:0] rc_fwd(input logic [RC_W-1:0] x);
        return {x[4:0], x[5] ^ x[4] ^ 1'b1};
    endfunction

    // Exact inverse of rc_fwd: recovers the bit shifted out at the top.
    function automatic logic [RC_W-1:0] rc_inv(input logic [RC_W-1:0] x);
        return {x[0] ^ x[5] ^ 1'b1, x[5:1]};
    endfunction

endpackage

// File: rtl/msk_share_const.sv
// Encodes one public bit as a d-share Boolean sharing: shares 1..d-1 are the
// supplied random bits, share 0 absorbs the data bit.
module msk_share_const #(
    parameter int D = 2
) (
    input  logic         b,
    input  logic [D-2:0] rnd,
    output logic [D-1:0] shares
);

    assign shares = {rnd, b ^ (^rnd)};

endmodule

// File: rtl/msk_round_const_gen.sv
// Masked SKINNY round-constant sequencer: walks the constant LFSR forward
// (encrypt) or backward after a wind-up (decrypt), emitting fresh sharings.
module msk_round_const_gen
    import skinny_msk_pkg::*;
#(
    parameter int d = 2,
    parameter int R = 56
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 decrypt,
    input  logic                 step,
    input  logic [6*(d-1)-1:0]   rnd,
    output logic [6*d-1:0]       roundcst,
    output logic                 valid,
    output logic                 last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [5:0] CNT_WIND_END = 6'(R - 2);
    localparam logic [5:0] CNT_LAST     = 6'(R - 1);
    localparam logic [RC_W-1:0] RC_FIRST = 6'h01;

    rc_state_e         state_reg, state_next;
    logic [RC_W-1:0]   lfsr_reg, lfsr_next;
    logic [5:0]        cnt_reg, cnt_next;
    logic              dec_reg, dec_next;
    logic              done_reg, done_next;
    logic [6*d-1:0]    shares_reg, shares_next;
    logic              load;
    logic              clear;

    logic [C0_W-1:0]   c0_pub;
    logic [C1_W-1:0]   c1_pub;
    logic [RC_W-1:0]   rc_pub;
    logic [6*d-1:0]    enc_shares;

    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        cnt_next   = cnt_reg;
        dec_next   = dec_reg;
        done_next  = 1'b0;
        load       = 1'b0;
        clear      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    lfsr_next  = RC_FIRST;
                    cnt_next   = '0;
                    dec_next   = decrypt;
                    load       = 1'b1;
                    state_next = decrypt ? WIND : RUN;
                end
            end
            WIND: begin
                // Advances on every cycle, including the exit cycle, so RUN starts at rc_R
                lfsr_next = rc_fwd(lfsr_reg);
                load      = 1'b1;
                if (cnt_reg == CNT_WIND_END) begin
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg + 6'd1;
                end
            end
            RUN: begin
                if (step) begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next = IDLE;
                        lfsr_next  = '0;
                        cnt_next   = '0;
                        clear      = 1'b1;
                        done_next  = 1'b1;
                    end else begin
                        lfsr_next = dec_reg ? rc_inv(lfsr_reg) : rc_fwd(lfsr_reg);
                        cnt_next  = cnt_reg + 6'd1;
                        load      = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sharings are built from the value being loaded, so rnd is consumed the same cycle
    assign c0_pub = lfsr_next[C0_LSB +: C0_W];
    assign c1_pub = lfsr_next[C1_LSB +: C1_W];
    assign rc_pub = {c1_pub, c0_pub};

    generate
        for (genvar gi = 0; gi < RC_W; gi++) begin : g_enc
            msk_share_const #(
                .D(d)
            ) u_enc (
                .b      (rc_pub[gi]),
                .rnd    (rnd[gi*(d-1) +: (d-1)]),
                .shares (enc_shares[gi*d +: d])
            );
        end
    endgenerate

    always_comb begin
        shares_next = shares_reg;
        if (clear) begin
            shares_next = '0;
        end else if (load) begin
            shares_next = enc_shares;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            lfsr_reg   <= '0;
            cnt_reg    <= '0;
            dec_reg    <= 1'b0;
            done_reg   <= 1'b0;
            shares_reg <= '0;
        end else begin
            state_reg  <= state_next;
            lfsr_reg   <= lfsr_next;
            cnt_reg    <= cnt_next;
            dec_reg    <= dec_next;
            done_reg   <= done_next;
            shares_reg <= shares_next;
        end
    end

    assign roundcst = shares_reg;
    assign valid    = (state_reg == RUN);
    assign last     = (state_reg == RUN) && (cnt_reg == CNT_LAST);
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;

endmodule

// File: tb/tb_msk_round_const_gen.sv
// Directed bench for msk_round_const_gen: three instances cover R=56/d=2,
// R=40/d=3 and R=48/d=2.
module tb_msk_round_const_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start_a = 0, decrypt_a = 0, step_a = 0;
    logic [5:0]  rnd_a = '0;
    logic [11:0] roundcst_a;
    logic        valid_a, last_a, busy_a, done_a;

    logic        start_b = 0, decrypt_b = 0, step_b = 0;
    logic [11:0] rnd_b = '0;
    logic [17:0] roundcst_b;
    logic        valid_b, last_b, busy_b, done_b;

    logic        start_c = 0, decrypt_c = 0, step_c = 0;
    logic [5:0]  rnd_c = '0;
    logic [11:0] roundcst_c;
    logic        valid_c, last_c, busy_c, done_c;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    msk_round_const_gen #(.d(2), .R(56)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .decrypt(decrypt_a), .step(step_a),
        .rnd(rnd_a), .roundcst(roundcst_a), .valid(valid_a), .last(last_a),
        .busy(busy_a), .done(done_a)
    );

    msk_round_const_gen #(.d(3), .R(40)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .decrypt(decrypt_b), .step(step_b),
        .rnd(rnd_b), .roundcst(roundcst_b), .valid(valid_b), .last(last_b),
        .busy(busy_b), .done(done_b)
    );

    msk_round_const_gen #(.d(2), .R(48)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .decrypt(decrypt_c), .step(step_c),
        .rnd(rnd_c), .roundcst(roundcst_c), .valid(valid_c), .last(last_c),
        .busy(busy_c), .done(done_c)
    );

    function automatic logic [5:0] m_fwd(input logic [5:0] x);
        return {x[4:0], ~(x[5] ^ x[4])};
    endfunction

    function automatic logic [5:0] m_inv(input logic [5:0] x);
        return {~(x[0] ^ x[5]), x[5:1]};
    endfunction

    function automatic logic [5:0] un2(input logic [11:0] v);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = v[2*i] ^ v[2*i+1];
        return r;
    endfunction

    function automatic logic [5:0] un3(input logic [17:0] v);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = v[3*i] ^ v[3*i+1] ^ v[3*i+2];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [5:0]  exp_rc;
        logic [11:0] hold;
        int          cyc;
        int          cyc_b;
        int          cyc_c;

        // Reset state
        tick();
        tick();
        chk("rst_roundcst", 32'(roundcst_a), 32'h0);
        chk("rst_valid", 32'(valid_a), 32'h0);
        chk("rst_last", 32'(last_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        rst_n = 1'b1;
        tick();

        // Encrypt R=56 with random masks
        start_a = 1; decrypt_a = 0; rnd_a = 6'($urandom);
        tick();
        start_a = 0;
        chk("enc_valid_first", 32'(valid_a), 32'h1);
        chk("enc_busy", 32'(busy_a), 32'h1);
        exp_rc = 6'h01;
        step_a = 1;
        for (int i = 0; i < 56; i++) begin
            chk($sformatf("enc_rc[%0d]", i), 32'(un2(roundcst_a)), 32'(exp_rc));
            chk($sformatf("enc_last[%0d]", i), 32'(last_a), (i == 55) ? 32'h1 : 32'h0);
            if (i == 5)  chk("enc_rc6_3e", 32'(un2(roundcst_a)), 32'h3E);
            if (i == 55) chk("enc_rc56_0a", 32'(un2(roundcst_a)), 32'h0A);
            exp_rc = m_fwd(exp_rc);
            rnd_a = 6'($urandom);
            tick();
        end
        step_a = 0;
        chk("enc_done", 32'(done_a), 32'h1);
        chk("enc_valid_after", 32'(valid_a), 32'h0);
        chk("enc_busy_after", 32'(busy_a), 32'h0);
        chk("enc_roundcst_clr", 32'(roundcst_a), 32'h0);
        tick();
        chk("enc_done_pulse", 32'(done_a), 32'h0);

        // Decrypt R=56: decrypt dropped right after start must not matter
        start_a = 1; decrypt_a = 1; rnd_a = 6'($urandom);
        tick();
        start_a = 0; decrypt_a = 0;
        cyc = 0;
        while (!valid_a && cyc < 100) begin
            rnd_a = 6'($urandom);
            tick();
            cyc++;
        end
        chk("dec_latency", 32'(cyc), 32'd55);
        exp_rc = 6'h0A;
        step_a = 1;
        for (int i = 0; i < 56; i++) begin
            chk($sformatf("dec_rc[%0d]", i), 32'(un2(roundcst_a)), 32'(exp_rc));
            chk($sformatf("dec_last[%0d]", i), 32'(last_a), (i == 55) ? 32'h1 : 32'h0);
            if (i == 3)  chk("dec_rc4_19", 32'(un2(roundcst_a)), 32'h19);
            if (i == 55) chk("dec_end_01", 32'(un2(roundcst_a)), 32'h01);
            exp_rc = m_inv(exp_rc);
            rnd_a = 6'($urandom);
            tick();
        end
        step_a = 0;
        chk("dec_done", 32'(done_a), 32'h1);
        chk("dec_valid_after", 32'(valid_a), 32'h0);
        tick();

        // Stall with step low; a start pulse during RUN is ignored
        start_a = 1; decrypt_a = 0;
        tick();
        start_a = 0; step_a = 1;
        repeat (5) tick();
        step_a = 0;
        chk("stall_rc6", 32'(un2(roundcst_a)), 32'h3E);
        hold = roundcst_a;
        for (int j = 0; j < 10; j++) begin
            rnd_a = 6'($urandom);
            start_a = (j == 4);
            decrypt_a = (j == 4);
            tick();
            chk($sformatf("stall_hold[%0d]", j), 32'(roundcst_a), 32'(hold));
        end
        start_a = 0; decrypt_a = 0;
        chk("stall_valid", 32'(valid_a), 32'h1);
        step_a = 1;
        tick();
        step_a = 0;
        chk("stall_rc7", 32'(un2(roundcst_a)), 32'h3D);
        chk("stall_last", 32'(last_a), 32'h0);

        // Asynchronous reset during RUN
        rst_n = 0;
        #1;
        chk("rstrun_roundcst", 32'(roundcst_a), 32'h0);
        chk("rstrun_valid", 32'(valid_a), 32'h0);
        chk("rstrun_busy", 32'(busy_a), 32'h0);
        chk("rstrun_done", 32'(done_a), 32'h0);
        tick();
        rst_n = 1;
        start_a = 1;
        tick();
        start_a = 0;
        chk("rstrun_restart", 32'(un2(roundcst_a)), 32'h01);

        // Asynchronous reset during WIND
        rst_n = 0; #1; rst_n = 1;
        tick();
        start_a = 1; decrypt_a = 1;
        tick();
        start_a = 0; decrypt_a = 0;
        repeat (5) tick();
        chk("wind_busy", 32'(busy_a), 32'h1);
        chk("wind_valid", 32'(valid_a), 32'h0);
        rst_n = 0;
        #1;
        chk("rstwind_busy", 32'(busy_a), 32'h0);
        chk("rstwind_roundcst", 32'(roundcst_a), 32'h0);
        chk("rstwind_last", 32'(last_a), 32'h0);
        tick();
        rst_n = 1;
        tick();
        chk("rstwind_no_done", 32'(done_a), 32'h0);
        start_a = 1;
        tick();
        start_a = 0;
        chk("rstwind_restart", 32'(un2(roundcst_a)), 32'h01);

        // Masking with rnd=0 (d=2) and rnd=all-ones (d=3)
        rst_n = 0; #1; rst_n = 1;
        tick();
        rnd_a = 6'h00; start_a = 1;
        rnd_b = 12'hFFF; start_b = 1; decrypt_b = 0;
        tick();
        start_a = 0; start_b = 0;
        chk("mask0_rc01", 32'(roundcst_a), 32'h001);
        chk("mask1_d3_rc01", 32'(roundcst_b), 32'h36DB7);
        step_a = 1;
        tick();
        step_a = 0;
        chk("mask0_rc03", 32'(roundcst_a), 32'h005);

        // Decrypt R=40 (d=3) and R=48 (d=2) side by side
        rst_n = 0; #1; rst_n = 1;
        tick();
        start_b = 1; decrypt_b = 1; rnd_b = 12'($urandom);
        start_c = 1; decrypt_c = 1; rnd_c = 6'($urandom);
        tick();
        start_b = 0; start_c = 0;
        cyc = 0; cyc_b = -1; cyc_c = -1;
        while (cyc < 60) begin
            rnd_b = 12'($urandom);
            rnd_c = 6'($urandom);
            tick();
            cyc++;
            if (valid_b && cyc_b < 0) cyc_b = cyc;
            if (valid_c && cyc_c < 0) cyc_c = cyc;
        end
        chk("r40_latency", 32'(cyc_b), 32'd39);
        chk("r48_latency", 32'(cyc_c), 32'd47);
        chk("r40_first_1a", 32'(un3(roundcst_b)), 32'h1A);
        chk("r48_first_04", 32'(un2(roundcst_c)), 32'h04);
        step_b = 1; step_c = 1;
        repeat (39) tick();
        step_b = 0;
        chk("r40_end_01", 32'(un3(roundcst_b)), 32'h01);
        chk("r40_end_last", 32'(last_b), 32'h1);
        repeat (8) tick();
        step_c = 0;
        chk("r48_end_01", 32'(un2(roundcst_c)), 32'h01);
        chk("r48_end_last", 32'(last_c), 32'h1);
        step_b = 1; step_c = 1;
        tick();
        step_b = 0; step_c = 0;
        chk("r40_done", 32'(done_b), 32'h1);
        chk("r48_done", 32'(done_c), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/msk_round_const_gen.md
# msk_round_const_gen

Masked SKINNY round-constant sequencer: the producer of the `roundcst` bus consumed by the masked AddConstants stage. It steps the 6-bit SKINNY constant LFSR forward for encryption or backward for decryption. It emits each constant as a d-share Boolean sharing, freshly remasked from an external randomness port. It sits beside the round datapath and advances one constant per `step` request.

## Interface
- `d`, 2: number of shares per bit, d ≥ 2.
- `R`, 56: rounds per block (40/48/56 for SKINNY-128-128/256/384), 2 ≤ R ≤ 63.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: begin a new constant sequence; sampled only in IDLE.
- `decrypt` in 1: sampled with `start`; 0 = forward order, 1 = reverse order.
- `step` in 1: round datapath consumed the current constant; sampled only in RUN.
- `rnd` in 6*(d-1): fresh randomness for remasking.
- `roundcst` out 6*d: shared constant. Bit i occupies `[(i+1)*d-1 : i*d]`. Bits 3..0 = c0 (rc[3:0]); bits 5..4 = c1 (rc[5:4]).
- `valid` out 1: `roundcst` holds a usable constant.
- `last` out 1: current constant belongs to the final round.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse after the final `step`.

## Operation
- LFSR update rules:
  - Forward: fwd(x) = {x[4:0], x[5]^x[4]^1}.
  - Inverse: inv(x) = {x[0]^x[5]^1, x[5:1]}.
  - Forward sequence from 0x00: 01,03,07,0F,1F,3E,…
- Share encoding, per bit i with data bit b:
  - shares 1..d-1 = `rnd[i*(d-1) +: d-1]`;
  - share 0 = b XOR (XOR of those d-1 random bits).
  - Share registers reload whenever `lfsr` loads, using `rnd` sampled in that same cycle. At all other times they hold.
- States:
  - IDLE: `start` loads lfsr←0x01 and cnt←0. Next state is RUN if `decrypt`=0, else WIND.
  - WIND: each cycle lfsr←fwd(lfsr), cnt←cnt+1. When cnt==R-2 go to RUN with cnt←0. After WIND, lfsr holds rc_R.
  - RUN: `valid`=1. On `step` with cnt<R-1: lfsr←fwd(lfsr) if encrypting, inv(lfsr) if decrypting; cnt←cnt+1. On `step` with cnt==R-1: go to IDLE, lfsr←0, shares←0, `done`←1.
- `last` = `valid` & (cnt==R-1).
- `start` outside IDLE is ignored. `step` outside RUN is ignored.
- `decrypt` is latched at start; later changes have no effect until the next start.
- Counter width is 6 bits; no wrap-around is reachable for the allowed R.

## Timing
- Reset values:
  - state = IDLE;
  - lfsr, cnt, `roundcst` = 0;
  - `valid`, `last`, `busy`, `done` = 0.
- `rst_n` low mid-sequence aborts immediately, with no `done` pulse.
- Encrypt latency: `start` at edge k → `valid`=1 with rc_1 after edge k.
- Decrypt latency: `valid` rises after edge k+R-1 (R-1 WIND cycles), with rc_R.
- `step` at edge j → next constant visible after edge j; one constant per cycle when `step` is held high.
- `done` is high for exactly the cycle after the final `step`. `start` may be asserted in that same cycle and is accepted.
- All outputs are registered; there is no combinational path from `rnd`, `step` or `start` to any output.

## Structure
- Shared package `skinny_msk_pkg` holds:
  - `RC_W`=6;
  - functions `rc_fwd` and `rc_inv`;
  - the c0/c1 bit-to-field mapping constants;
  - the state enum {IDLE, WIND, RUN}.
- Sub-module `msk_share_const`: combinational 1-bit public-to-d-share encoder, instantiated 6 times.

## Test plan
- Encrypt, R=56, `rnd` random: unshared XOR of shares gives 01,03,07,0F,1F,3E on successive steps. `last` rises at the 56th constant, 0x0A. `done` pulses once, then `valid`=0.
- Decrypt, R=56: `valid` rises 55 cycles after `start`. Sequence is 0A,25,32,19,…, ending at 01 with `last`=1.
- Decrypt, R=40: first constant 0x1A. R=48: first constant 0x04. Both end at 0x01.
- `step` held low for 10 cycles mid-run: `roundcst` shares are bit-identical throughout. `start` pulsed during RUN is ignored.
- `rst_n` asserted during WIND and during RUN: all outputs zero immediately. A fresh encrypt start afterwards yields 0x01.
- Masking check:
  - `rnd`=0 → share 0 equals rc, other shares 0;
  - `rnd`=all-ones, d=3 → shares 1,2 all-ones and share 0 equals rc.
